// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared width constants, MEM-stage FSM encoding and the default
//          data-memory watchdog limit for the 5-stage pipeline.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int unsigned CPU_PC_WIDTH        = 15;
  localparam int unsigned CPU_DATA_WIDTH      = 16;
  localparam int unsigned CPU_REGADDR_WIDTH   = 4;
  localparam int unsigned CPU_DMEM_ADDR_WIDTH = 12;
  localparam int unsigned CPU_TIMEOUT_CYCLES  = 15;

  // MEM-stage access FSM encoding
  localparam int unsigned MEM_STATE_W = 1;
  typedef logic [MEM_STATE_W-1:0] mem_state_t;
  localparam mem_state_t ST_IDLE = 1'b0;
  localparam mem_state_t ST_BUSY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_wb_reg.sv
// ============================================================================
// Module : mem_wb_reg
// Brief  : MEM/WB pipeline register. Loads every cycle; a bubble suppresses
//          the writeback enable, a synchronous clear zeroes the whole bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_reg #(
  parameter int unsigned PC_WIDTH      = 15,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned REGADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic                     i_bubble,
  input  logic                     i_reg_write,
  input  logic [REGADDR_WIDTH-1:0] i_rd,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic [PC_WIDTH-1:0]      i_pc,
  output logic                     o_reg_write,
  output logic [REGADDR_WIDTH-1:0] o_rd,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic [PC_WIDTH-1:0]      o_pc
);

  logic                     r_reg_write;
  logic [REGADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [PC_WIDTH-1:0]      r_pc;

  // Capture the writeback bundle each cycle; bubbles never write the regfile
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
      r_pc        <= '0;
    end else begin
      r_reg_write <= i_reg_write & ~i_bubble;
      r_rd        <= i_rd;
      r_data      <= i_data;
      r_pc        <= i_pc;
    end
  end

  assign o_reg_write = r_reg_write;
  assign o_rd        = r_rd;
  assign o_data      = r_data;
  assign o_pc        = r_pc;

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module : mem_access_stage
// Brief  : MEM stage with req/ack data-memory port, upstream stall and the
//          MEM/WB register. Optional watchdog enabled by MEM_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH        = CPU_PC_WIDTH,
  parameter int unsigned DATA_WIDTH      = CPU_DATA_WIDTH,
  parameter int unsigned REGADDR_WIDTH   = CPU_REGADDR_WIDTH,
  parameter int unsigned DMEM_ADDR_WIDTH = CPU_DMEM_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES  = CPU_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_reg_write,
  input  logic                       mem_mem_read,
  input  logic                       mem_mem_write,
  input  logic [PC_WIDTH-1:0]        mem_pc,
  input  logic [DATA_WIDTH-1:0]      mem_alu_result,
  input  logic [DATA_WIDTH-1:0]      mem_write_data,
  input  logic [REGADDR_WIDTH-1:0]   mem_rd,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]      dmem_wdata,
  input  logic                       dmem_ack,
  input  logic [DATA_WIDTH-1:0]      dmem_rdata,
  output logic                       mem_stall,
  output logic                       wb_reg_write,
  output logic [REGADDR_WIDTH-1:0]   wb_rd,
  output logic [DATA_WIDTH-1:0]      wb_data,
  output logic [PC_WIDTH-1:0]        wb_pc,
  output logic                       mem_fault
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  mem_state_t r_state;
  mem_state_t w_state_nxt;

  // Transaction copy; authoritative while BUSY
  logic                       r_req;
  logic                       r_we;
  logic [DMEM_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [DATA_WIDTH-1:0]      r_alu;
  logic [REGADDR_WIDTH-1:0]   r_rd;
  logic [PC_WIDTH-1:0]        r_pc;
  logic                       r_reg_write;
  logic                       r_is_load;

  logic                       w_access;
  logic                       w_busy_ack;
  logic                       w_timeout;
  logic                       w_wb_clear;
  logic                       w_wb_bubble;
  logic                       w_wb_reg_write;
  logic [REGADDR_WIDTH-1:0]   w_wb_rd;
  logic [DATA_WIDTH-1:0]      w_wb_data;
  logic [PC_WIDTH-1:0]        w_wb_pc;

  // A simultaneous read+write is a store, so only a pure read is a load
  assign w_access   = mem_mem_read | mem_mem_write;
  assign w_busy_ack = (r_state == ST_BUSY) & dmem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_fault;

  assign w_timeout = (r_state == ST_BUSY) & ~dmem_ack &
                     (r_to_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Count BUSY cycles without ack; the fault flag is sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_fault  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_access) begin
        r_to_cnt <= '0;
      end else if (r_state == ST_BUSY && !dmem_ack && !w_timeout) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign mem_fault = r_fault;
`else
  assign w_timeout = 1'b0;
  assign mem_fault = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: enter BUSY on an access, leave on ack or watchdog expiry
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_access) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_busy_ack || w_timeout) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: stall and the bundle presented to the MEM/WB register
  always_comb begin
    mem_stall      = 1'b0;
    w_wb_clear     = 1'b0;
    w_wb_bubble    = 1'b0;
    w_wb_reg_write = mem_reg_write;
    w_wb_rd        = mem_rd;
    w_wb_data      = mem_alu_result;
    w_wb_pc        = mem_pc;
    case (r_state)
      ST_IDLE: begin
        mem_stall   = w_access;
        w_wb_bubble = w_access;
      end
      ST_BUSY: begin
        mem_stall      = ~dmem_ack & ~w_timeout;
        w_wb_bubble    = ~dmem_ack;
        w_wb_clear     = w_timeout;
        w_wb_reg_write = r_reg_write;
        w_wb_rd        = r_rd;
        w_wb_data      = r_is_load ? dmem_rdata : r_alu;
        w_wb_pc        = r_pc;
      end
      default: begin
        mem_stall = 1'b0;
      end
    endcase
  end

  // Latch the transaction on entry to BUSY and drop the request on exit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_alu       <= '0;
      r_rd        <= '0;
      r_pc        <= '0;
      r_reg_write <= 1'b0;
      r_is_load   <= 1'b0;
    end else if (r_state == ST_IDLE && w_access) begin
      r_req       <= 1'b1;
      r_we        <= mem_mem_write;
      r_addr      <= mem_alu_result[DMEM_ADDR_WIDTH-1:0];
      r_wdata     <= mem_write_data;
      r_alu       <= mem_alu_result;
      r_rd        <= mem_rd;
      r_pc        <= mem_pc;
      r_reg_write <= mem_reg_write;
      r_is_load   <= mem_mem_read & ~mem_mem_write;
    end else if (w_busy_ack || w_timeout) begin
      r_req <= 1'b0;
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;

  mem_wb_reg #(
    .PC_WIDTH      (PC_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .REGADDR_WIDTH (REGADDR_WIDTH)
  ) u_mem_wb_reg (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_wb_clear),
    .i_bubble    (w_wb_bubble),
    .i_reg_write (w_wb_reg_write),
    .i_rd        (w_wb_rd),
    .i_data      (w_wb_data),
    .i_pc        (w_wb_pc),
    .o_reg_write (wb_reg_write),
    .o_rd        (wb_rd),
    .o_data      (wb_data),
    .o_pc        (wb_pc)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module : tb_mem_access_stage
// Brief  : Scoreboard bench for mem_access_stage. The driver issues one
//          instruction per pipeline slot and acts as data memory; expected
//          writeback bundles and stall counts are queued and a monitor pops
//          and compares each retirement.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  localparam int unsigned PW = 15;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_reg_write, mem_mem_read, mem_mem_write;
  logic [PW-1:0] mem_pc;
  logic [DW-1:0] mem_alu_result, mem_write_data;
  logic [RW-1:0] mem_rd;
  logic          dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic          mem_stall;
  logic          wb_reg_write;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [PW-1:0] wb_pc;
  logic          mem_fault;

  mem_access_stage #(
    .PC_WIDTH(PW), .DATA_WIDTH(DW), .REGADDR_WIDTH(RW),
    .DMEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_pc(mem_pc),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .mem_rd(mem_rd), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc(wb_pc), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rw;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic [PW-1:0] pc;
    logic [7:0]    stalls;
    logic          to;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   active = 1'b0;
  int   stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: an instruction retires at every edge where the stage was not stalled
  always @(posedge clk) begin : mon
    logic s_stall, s_act, s_rst;
    exp_t e;
    s_stall = mem_stall;
    s_act   = active;
    s_rst   = reset;
    #1;
    if (!s_rst && s_act) begin
      if (s_stall) begin
        stall_cnt++;
      end else begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wb_unexpected: got retirement expected none");
        end else begin
          e = q.pop_front();
          check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
          check("wb_data", 32'(wb_data), 32'(e.data));
          if (!e.to) begin
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
            check("wb_pc", 32'(wb_pc), 32'(e.pc));
          end
          check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
        end
        stall_cnt = 0;
      end
    end
  end

  // Issue one instruction at a negedge and play data memory until it retires
  task automatic issue(input logic rw, input logic [RW-1:0] rd, input logic rd_en,
                       input logic wr_en, input logic [DW-1:0] alu,
                       input logic [DW-1:0] wd, input logic [PW-1:0] pc,
                       input int lat, input logic [DW-1:0] rdata);
    exp_t e;
    check("dmem_req_idle", 32'(dmem_req), 32'd0);
    mem_reg_write  = rw;
    mem_rd         = rd;
    mem_mem_read   = rd_en;
    mem_mem_write  = wr_en;
    mem_alu_result = alu;
    mem_write_data = wd;
    mem_pc         = pc;
    e.rw     = rw;
    e.rd     = rd;
    e.pc     = pc;
    e.data   = (rd_en && !wr_en) ? rdata : alu;
    e.stalls = (rd_en || wr_en) ? 8'(lat) : 8'd0;
    e.to     = 1'b0;
    q.push_back(e);
    if (!(rd_en || wr_en)) begin
      dmem_ack   = 1'($urandom);
      dmem_rdata = 16'($urandom);
      @(negedge clk);
    end else begin
      dmem_ack = 1'b0;
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        check("dmem_req", 32'(dmem_req), 32'd1);
        check("dmem_addr", 32'(dmem_addr), 32'(alu[AW-1:0]));
        check("dmem_we", 32'(dmem_we), 32'(wr_en));
        if (wr_en) check("dmem_wdata", 32'(dmem_wdata), 32'(wd));
        dmem_ack   = (k == lat);
        dmem_rdata = (k == lat) ? rdata : 16'($urandom);
      end
      @(negedge clk);
      dmem_ack = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    mem_reg_write = 0; mem_mem_read = 0; mem_mem_write = 0;
    mem_pc = '0; mem_alu_result = '0; mem_write_data = '0; mem_rd = '0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_dmem_addr", 32'(dmem_addr), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_wb_pc", 32'(wb_pc), 32'd0);
    check("rst_mem_fault", 32'(mem_fault), 32'd0);
    reset  = 1'b0;
    active = 1'b1;

    // Directed: ALU op, slow load, fast store, load followed by ALU op
    issue(1'b1, 4'd5, 1'b0, 1'b0, 16'h1234, 16'h0000, 15'h0100, 0, 16'h0);
    issue(1'b1, 4'd3, 1'b1, 1'b0, 16'h0040, 16'h0000, 15'h0104, 3, 16'hBEEF);
    issue(1'b0, 4'd0, 1'b0, 1'b1, 16'h0012, 16'hA5A5, 15'h0108, 1, 16'h0);
    issue(1'b1, 4'd7, 1'b1, 1'b0, 16'hF123, 16'h0000, 15'h010C, 1, 16'h5A5A);
    issue(1'b1, 4'd8, 1'b0, 1'b0, 16'h00AA, 16'h0000, 15'h0110, 0, 16'h0);
    issue(1'b1, 4'd9, 1'b1, 1'b1, 16'h3456, 16'h7777, 15'h0114, 2, 16'hDEAD);

    // Randomized instruction stream
    for (int i = 0; i < 250; i++) begin
      int unsigned kind;
      kind = $urandom_range(0, 5);
      issue(1'($urandom), 4'($urandom), (kind == 2 || kind == 4), (kind == 3 || kind == 4),
            16'($urandom), 16'($urandom), 15'($urandom), int'($urandom_range(1, 6)),
            16'($urandom));
    end
    idle_inputs();
    active = 1'b0;
    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("mem_fault_clear", 32'(mem_fault), 32'd0);

    // Reset during BUSY, then a late ack that must be ignored
    mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_rd = 4'd6; mem_alu_result = 16'h0321;
    @(negedge clk);
    check("busy_req", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("rstbusy_req", 32'(dmem_req), 32'd0);
    check("rstbusy_stall", 32'(mem_stall), 32'd0);
    check("rstbusy_wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("rstbusy_wb_rd", 32'(wb_rd), 32'd0);
    check("rstbusy_wb_data", 32'(wb_data), 32'd0);
    check("rstbusy_wb_pc", 32'(wb_pc), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 16'hCAFE;
    check("late_ack_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    dmem_ack = 1'b0;
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("late_ack_wb_data", 32'(wb_data), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // Load whose ack never comes: watchdog releases the stall and flags a fault
    begin
      exp_t e;
      active = 1'b1;
      e.rw = 1'b0; e.rd = '0; e.data = '0; e.pc = '0;
      e.stalls = 8'(TO + 1); e.to = 1'b1;
      q.push_back(e);
      mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_rd = 4'd2; mem_alu_result = 16'h0777;
      for (int k = 1; k <= TO + 1; k++) begin
        @(negedge clk);
        check("to_req", 32'(dmem_req), 32'd1);
      end
      idle_inputs();
      @(negedge clk);
      check("to_req_drop", 32'(dmem_req), 32'd0);
      check("to_fault", 32'(mem_fault), 32'd1);
      issue(1'b1, 4'd4, 1'b0, 1'b0, 16'h4444, 16'h0, 15'h0200, 0, 16'h0);
      idle_inputs();
      active = 1'b0;
      check("to_fault_sticky", 32'(mem_fault), 32'd1);
      check("to_queue_drained", 32'(q.size()), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
